wavegen_pdm: RTL and testbench

WAVEGEN_PDM -- requirements
Module: wavegen_pdm

---
 rtl/wavegen_pdm_pkg.sv | 35 +++
 rtl/wavegen_pdm_pdm.sv | 27 ++
 rtl/wavegen_pdm.sv | 78 +++++++
 tb/tb_wavegen_pdm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wavegen_pdm_pkg.sv
// Shared types and waveform mapping for the wavegen_pdm generator.
package wavegen_pdm_pkg;

  typedef enum logic [1:0] {
    MODE_SAW = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SQR = 2'd2,
    MODE_RDN = 2'd3
  } wave_mode_e;

  localparam int MAX_W = 32;

  // Maps a w-bit phase to a w-bit sample; results are zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] wave_map(input logic [MAX_W-1:0] p,
                                                input wave_mode_e m,
                                                input int w);
    logic [MAX_W-1:0] mask_v;
    logic [MAX_W-1:0] msb_v;
    logic [MAX_W-1:0] tri_v;
    logic [MAX_W-1:0] res_v;
    mask_v = (32'd1 << w) - 32'd1;
    msb_v  = p & (32'd1 << (w - 1));
    tri_v  = (p << 1) & mask_v;
    res_v  = p & mask_v;
    case (m)
      MODE_SAW: res_v = p & mask_v;
      MODE_TRI: res_v = (msb_v != 32'd0) ? (~tri_v & mask_v) : tri_v;
      MODE_SQR: res_v = (msb_v != 32'd0) ? 32'd0 : mask_v;
      MODE_RDN: res_v = ~p & mask_v;
      default:  res_v = p & mask_v;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/wavegen_pdm_pdm.sv
// First-order sigma-delta modulator: the carry of a running sum is the bitstream.
module pdm_modulator
  import wavegen_pdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] sample,
  output logic             pdm
);

  logic [WIDTH:0] acc_r;

  // Accumulate the sample onto the residue, keeping the carry as the output bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {(WIDTH+1){1'b0}};
    end else if (ena) begin
      acc_r <= {1'b0, acc_r[WIDTH-1:0]} + {1'b0, sample};
    end
  end

  assign pdm = acc_r[WIDTH];

endmodule

// File: rtl/wavegen_pdm.sv
// Prescaled phase accumulator driving a selectable waveform and a PDM output.
module wavegen_pdm
  import wavegen_pdm_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [SHIFT_W-1:0] shift_by,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   sample_out,
  output logic               pdm_out,
  output logic               wrap_pulse
);

  localparam int PRE_W = 2**SHIFT_W - 1;

  logic [PRE_W-1:0] count_r;
  logic [PRE_W-1:0] mask_s;
  logic             step_s;
  logic             wrap_s;
  logic [WIDTH-1:0] phase_r;
  logic [WIDTH-1:0] sample_r;
  logic             wrap_r;
  wave_mode_e       active_mode_r;

  // Step decode; the >= compare lets a shrinking divider fire without waiting for a wrap.
  always_comb begin
    mask_s = (PRE_W'(1) << shift_by) - PRE_W'(1);
    step_s = 1'b0;
    wrap_s = 1'b0;
    if (count_r >= mask_s) begin
      step_s = 1'b1;
      wrap_s = (phase_r == {WIDTH{1'b1}});
    end else begin
      step_s = 1'b0;
      wrap_s = 1'b0;
    end
  end

  // Prescaler, phase, mode latch and registered sample/wrap outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r       <= {PRE_W{1'b0}};
      phase_r       <= {WIDTH{1'b0}};
      sample_r      <= {WIDTH{1'b0}};
      active_mode_r <= MODE_SAW;
      wrap_r        <= 1'b0;
    end else if (ena) begin
      count_r  <= step_s ? {PRE_W{1'b0}} : count_r + PRE_W'(1);
      if (step_s) begin
        phase_r <= phase_r + WIDTH'(1);
      end
      // Mode is only adopted at the phase wrap so a period is never mixed.
      if (wrap_s) begin
        active_mode_r <= wave_mode_e'(mode);
      end
      sample_r <= WIDTH'(wave_map(MAX_W'(phase_r), active_mode_r, WIDTH));
      wrap_r   <= wrap_s;
    end else begin
      wrap_r <= 1'b0;
    end
  end

  pdm_modulator #(.WIDTH(WIDTH)) u_pdm (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .sample (sample_r),
    .pdm    (pdm_out)
  );

  assign sample_out = sample_r;
  assign wrap_pulse = wrap_r;

endmodule

// File: tb/tb_wavegen_pdm.sv
// Self-checking bench for wavegen_pdm against an arithmetic reference model.
module tb_wavegen_pdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] shift_by = 4'd0;
  logic [1:0] mode = 2'd0;
  logic [7:0] sample_out;
  logic       pdm_out;
  logic       wrap_pulse;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int     m_cnt, m_phase, m_mode, m_sample, m_wrap, m_pdm;
  longint m_total;

  wavegen_pdm #(.WIDTH(8), .SHIFT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .shift_by   (shift_by),
    .mode       (mode),
    .sample_out (sample_out),
    .pdm_out    (pdm_out),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  function automatic int ref_wave(int p, int md);
    case (md)
      0:       return p;
      1:       return (p < 128) ? 2 * p : 511 - 2 * p;
      2:       return (p < 128) ? 255 : 0;
      default: return 255 - p;
    endcase
  endfunction

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    int     mask;
    bit     step;
    longint prev;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_phase = 0; m_mode = 0; m_sample = 0;
      m_wrap = 0; m_pdm = 0; m_total = 0;
    end else if (!ena) begin
      m_wrap = 0;
    end else begin
      mask = (1 << shift_by) - 1;
      step = (m_cnt >= mask);
      prev = m_total;
      m_total = m_total + m_sample;
      m_pdm = ((m_total / 256) != (prev / 256)) ? 1 : 0;
      m_wrap = (step && m_phase == 255) ? 1 : 0;
      m_sample = ref_wave(m_phase, m_mode);
      if (m_wrap != 0) m_mode = mode;
      m_cnt = step ? 0 : m_cnt + 1;
      if (step) m_phase = (m_phase + 1) % 256;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b1; shift_by = 4'd0; mode = 2'd0;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (sample_out !== 8'h00) begin n_err++; $display("FAIL reset_sample: got %0h expected 0", sample_out); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %0b expected 0", wrap_pulse); end
    n_cmp++; if (pdm_out !== 1'b0) begin n_err++; $display("FAIL reset_pdm: got %0b expected 0", pdm_out); end
  endtask

  task automatic test_saw();
    int wraps = 0;
    ena = 1'b1; shift_by = 4'd0; mode = 2'd0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (wrap_pulse === 1'b1) wraps++;
      n_cmp++; if (sample_out !== 8'(i % 256)) begin n_err++; $display("FAIL saw_sample cyc %0d: got %0h expected %0h", i, sample_out, i % 256); end
      n_cmp++; if (wrap_pulse !== ((i % 256) == 255)) begin n_err++; $display("FAIL saw_wrap cyc %0d: got %0b expected %0b", i, wrap_pulse, (i % 256) == 255); end
      n_cmp++; if (pdm_out !== m_pdm[0]) begin n_err++; $display("FAIL saw_pdm cyc %0d: got %0b expected %0b", i, pdm_out, m_pdm[0]); end
    end
    n_cmp++; if (wraps != 1) begin n_err++; $display("FAIL saw_wrap_count: got %0d expected 1", wraps); end
  endtask

  task automatic test_prescale();
    int p0;
    int guard = 0;
    ena = 1'b1; shift_by = 4'd3; mode = 2'd0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++; if (sample_out !== 8'(m_sample)) begin n_err++; $display("FAIL pre_sample cyc %0d: got %0h expected %0h", i, sample_out, m_sample); end
      n_cmp++; if (sample_out !== 8'(i / 8)) begin n_err++; $display("FAIL pre_rate cyc %0d: got %0h expected %0h", i, sample_out, i / 8); end
    end
    while (m_cnt != 5 && guard < 20) begin tick(); guard++; end
    n_cmp++; if (m_cnt != 5) begin n_err++; $display("FAIL pre_timeout: got count %0d expected 5", m_cnt); end
    p0 = m_phase;
    shift_by = 4'd0;
    tick(); tick();
    n_cmp++; if (sample_out !== 8'(p0 + 1)) begin n_err++; $display("FAIL pre_shrink: got %0h expected %0h", sample_out, p0 + 1); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (sample_out !== 8'(m_sample)) begin n_err++; $display("FAIL pre_after cyc %0d: got %0h expected %0h", i, sample_out, m_sample); end
    end
  endtask

  task automatic test_mode_switch();
    int guard = 0;
    ena = 1'b1; shift_by = 4'd0; mode = 2'd0;
    do_reset();
    while (m_phase != 'h20 && guard < 600) begin tick(); guard++; end
    mode = 2'd1;
    guard = 0;
    while (wrap_pulse !== 1'b1 && guard < 300) begin
      tick(); guard++;
      n_cmp++; if (sample_out !== 8'(m_sample)) begin n_err++; $display("FAIL ms_pre cyc %0d: got %0h expected %0h", guard, sample_out, m_sample); end
    end
    n_cmp++; if (wrap_pulse !== 1'b1) begin n_err++; $display("FAIL ms_timeout: got wrap %0b expected 1", wrap_pulse); end
    n_cmp++; if (sample_out !== 8'hFF) begin n_err++; $display("FAIL ms_last_saw: got %0h expected ff", sample_out); end
    for (int k = 1; k <= 'hC1; k++) begin
      tick();
      n_cmp++; if (sample_out !== 8'(m_sample)) begin n_err++; $display("FAIL ms_tri k %0d: got %0h expected %0h", k, sample_out, m_sample); end
      if (k == 'h41) begin
        n_cmp++; if (sample_out !== 8'h80) begin n_err++; $display("FAIL ms_tri_40: got %0h expected 80", sample_out); end
      end
      if (k == 'hC1) begin
        n_cmp++; if (sample_out !== 8'h7F) begin n_err++; $display("FAIL ms_tri_c0: got %0h expected 7f", sample_out); end
      end
    end
  endtask

  task automatic test_pdm();
    int guard = 0;
    int highs = 0;
    int last = -1;
    int bad = 0;
    ena = 1'b1; shift_by = 4'd0; mode = 2'd0;
    do_reset();
    while (m_phase != 'h40 && guard < 600) begin tick(); guard++; end
    shift_by = 4'd15;
    tick(); tick();
    for (int i = 0; i < 256; i++) begin
      tick();
      n_cmp++; if (pdm_out !== m_pdm[0]) begin n_err++; $display("FAIL pdm_model cyc %0d: got %0b expected %0b", i, pdm_out, m_pdm[0]); end
      if (pdm_out === 1'b1) begin
        highs++;
        if (last >= 0 && i - last != 4) bad++;
        last = i;
      end
    end
    n_cmp++; if (highs != 64) begin n_err++; $display("FAIL pdm_quarter: got %0d highs expected 64", highs); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL pdm_spacing: got %0d bad gaps expected 0", bad); end
    mode = 2'd2; shift_by = 4'd0;
    do_reset();
    guard = 0;
    while (wrap_pulse !== 1'b1 && guard < 600) begin tick(); guard++; end
    n_cmp++; if (wrap_pulse !== 1'b1) begin n_err++; $display("FAIL pdm_sq_timeout: got wrap %0b expected 1", wrap_pulse); end
    shift_by = 4'd15;
    tick();
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pdm_out === 1'b1) highs++;
    end
    n_cmp++; if (highs != 255) begin n_err++; $display("FAIL pdm_full: got %0d highs expected 255", highs); end
  endtask

  task automatic test_ena();
    logic [7:0] s_hold;
    logic       p_hold;
    ena = 1'b1; shift_by = 4'd3; mode = 2'($urandom_range(0, 3));
    do_reset();
    repeat (21) tick();
    s_hold = sample_out; p_hold = pdm_out;
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (sample_out !== s_hold) begin n_err++; $display("FAIL ena_sample cyc %0d: got %0h expected %0h", i, sample_out, s_hold); end
      n_cmp++; if (pdm_out !== p_hold) begin n_err++; $display("FAIL ena_pdm cyc %0d: got %0b expected %0b", i, pdm_out, p_hold); end
      n_cmp++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL ena_wrap cyc %0d: got %0b expected 0", i, wrap_pulse); end
    end
    ena = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_cmp++; if (sample_out !== 8'(m_sample)) begin n_err++; $display("FAIL ena_resume cyc %0d: got %0h expected %0h", i, sample_out, m_sample); end
      n_cmp++; if (pdm_out !== m_pdm[0]) begin n_err++; $display("FAIL ena_resume_pdm cyc %0d: got %0b expected %0b", i, pdm_out, m_pdm[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic [7:0] prev;
    ena = 1'b1; shift_by = 4'd0; mode = 2'd0;
    do_reset();
    while (m_phase != 'h90 && guard < 600) begin tick(); guard++; end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (sample_out !== 8'h00) begin n_err++; $display("FAIL rmid_sample: got %0h expected 0", sample_out); end
    n_cmp++; if (pdm_out !== 1'b0) begin n_err++; $display("FAIL rmid_pdm: got %0b expected 0", pdm_out); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL rmid_wrap: got %0b expected 0", wrap_pulse); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (sample_out !== 8'(i)) begin n_err++; $display("FAIL rmid_restart cyc %0d: got %0h expected %0h", i, sample_out, i); end
    end
    prev = sample_out;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (sample_out !== prev + 8'd1) begin n_err++; $display("FAIL rglitch: got %0h expected %0h", sample_out, prev + 8'd1); end
    n_cmp++; if (pdm_out !== m_pdm[0]) begin n_err++; $display("FAIL rglitch_pdm: got %0b expected %0b", pdm_out, m_pdm[0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ena      = ($urandom_range(0, 9) != 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      shift_by = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      tick();
      n_cmp++; if (sample_out !== 8'(m_sample)) begin n_err++; $display("FAIL rnd_sample cyc %0d: got %0h expected %0h", i, sample_out, m_sample); end
      n_cmp++; if (wrap_pulse !== m_wrap[0]) begin n_err++; $display("FAIL rnd_wrap cyc %0d: got %0b expected %0b", i, wrap_pulse, m_wrap[0]); end
      n_cmp++; if (pdm_out !== m_pdm[0]) begin n_err++; $display("FAIL rnd_pdm cyc %0d: got %0b expected %0b", i, pdm_out, m_pdm[0]); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_prescale();
    test_mode_switch();
    test_pdm();
    test_ena();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
